// File: rtl/ps2_rx_filt.sv
// rtl/ps2_rx_filt.sv - PS/2 device-to-host receiver with clock glitch filter and timeout
module ps2_rx_filt #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 1,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data_in,
    output logic [DATA_BITS-1:0] ps2_data_out,
    output logic                 valid,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_timeout,
    output logic                 busy
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    RUN_MAX = 4'(FILT_LEN - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic filt_q, filt_d;
    logic [3:0] run_q, run_d;
    logic fall;

    state_t state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [TW-1:0]        to_q, to_d;
    logic valid_q, valid_d, eparity_q, eparity_d, eframe_q, eframe_d, etimeout_q, etimeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            run_q    <= '0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_in;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            run_q    <= run_d;
        end
    end

    // The filtered level flips on the FILT_LEN-th consecutive differing sample.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        fall   = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (run_q == RUN_MAX) begin
                filt_d = clk_s2_q;
                fall   = filt_q;
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            data_q     <= '0;
            to_q       <= '0;
            valid_q    <= 1'b0;
            eparity_q  <= 1'b0;
            eframe_q   <= 1'b0;
            etimeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            data_q     <= data_d;
            to_q       <= to_d;
            valid_q    <= valid_d;
            eparity_q  <= eparity_d;
            eframe_q   <= eframe_d;
            etimeout_q <= etimeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        eparity_d  = 1'b0;
        eframe_d   = 1'b0;
        etimeout_d = 1'b0;
        to_d       = (state_q == IDLE || fall) ? '0 : to_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (cnt_q == 4'(i)) shift_d[i] = dat_s2_q;
                    end
                    if (cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (!dat_s2_q) begin
                        eframe_d = 1'b1;
                    end else if (PARITY_EN != 0 && !(^shift_q ^ par_q)) begin
                        eparity_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A falling edge in the expiry cycle wins, so the frame keeps going.
        if (state_q != IDLE && !fall && to_q == TO_MAX) begin
            state_d    = IDLE;
            shift_d    = '0;
            cnt_d      = '0;
            to_d       = '0;
            etimeout_d = 1'b1;
        end
    end

    assign ps2_data_out = data_q;
    assign valid        = valid_q;
    assign err_parity   = eparity_q;
    assign err_frame    = eframe_q;
    assign err_timeout  = etimeout_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_filt.sv
// tb/tb_ps2_rx_filt.sv - scoreboard bench for ps2_rx_filt (default and 7-bit/no-parity builds)
module tb_ps2_rx_filt;

    localparam int HALF = 30;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic clk = 1'b0;
    logic rst0_n, rst1_n;
    logic ps2c [2];
    logic ps2d [2];

    logic [7:0] dout0;
    logic [6:0] dout1;
    logic valid0, ep0, ef0, et0, busy0;
    logic valid1, ep1, ef1, et1, busy1;

    ev_t q0[$];
    ev_t q1[$];
    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ps2_rx_filt dut0 (
        .clk(clk), .rst_n(rst0_n), .ps2_clk(ps2c[0]), .ps2_data_in(ps2d[0]),
        .ps2_data_out(dout0), .valid(valid0), .err_parity(ep0), .err_frame(ef0),
        .err_timeout(et0), .busy(busy0)
    );

    ps2_rx_filt #(.DATA_BITS(7), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst_n(rst1_n), .ps2_clk(ps2c[1]), .ps2_data_in(ps2d[1]),
        .ps2_data_out(dout1), .valid(valid1), .err_parity(ep1), .err_frame(ef1),
        .err_timeout(et1), .busy(busy1)
    );

    task automatic chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    always @(negedge clk) begin : mon0
        int k;
        ev_t e;
        if (valid0 | ep0 | ef0 | et0) begin
            chk("onehot0", $countones({valid0, ep0, ef0, et0}), 1);
            k = valid0 ? 0 : ep0 ? 1 : ef0 ? 2 : 3;
            if (q0.size() == 0) begin
                chk("spurious_event0", k, -1);
            end else begin
                e = q0.pop_front();
                chk("kind0", k, e.kind);
                chk("data0", int'(dout0), e.data);
            end
        end
    end

    always @(negedge clk) begin : mon1
        int k;
        ev_t e;
        if (valid1 | ep1 | ef1 | et1) begin
            chk("onehot1", $countones({valid1, ep1, ef1, et1}), 1);
            k = valid1 ? 0 : ep1 ? 1 : ef1 ? 2 : 3;
            if (q1.size() == 0) begin
                chk("spurious_event1", k, -1);
            end else begin
                e = q1.pop_front();
                chk("kind1", k, e.kind);
                chk("data1", int'(dout1), e.data);
            end
        end
    end

    task automatic send_bit(int u, logic b, int glen);
        ps2d[u] = b;
        repeat (10) @(negedge clk);
        if (glen > 0) begin
            ps2c[u] = 1'b0;
            repeat (glen) @(negedge clk);
            ps2c[u] = 1'b1;
        end
        repeat (HALF - 10) @(negedge clk);
        ps2c[u] = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2c[u] = 1'b1;
    endtask

    task automatic send_frame(int u, int nb, int data, bit pen, bit pflip, bit stop,
                              int gbit, int glen);
        logic p;
        p = 1'b1;
        send_bit(u, 1'b0, 0);
        for (int i = 0; i < nb; i++) begin
            send_bit(u, data[i], (i == gbit) ? glen : 0);
            p ^= data[i];
        end
        if (pen) send_bit(u, p ^ pflip, 0);
        send_bit(u, stop, 0);
        ps2d[u] = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic drain(int u);
        repeat (100) @(negedge clk);
        if (u == 0) chk("drain0", q0.size(), 0);
        else        chk("drain1", q1.size(), 0);
    endtask

    initial begin
        ps2c[0] = 1'b1; ps2d[0] = 1'b1;
        ps2c[1] = 1'b1; ps2d[1] = 1'b1;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_dout0", int'(dout0), 0);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_flags0", int'({valid0, ep0, ef0, et0}), 0);
        chk("rst_dout1", int'(dout1), 0);
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_flags1", int'({valid1, ep1, ef1, et1}), 0);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        repeat (10) @(negedge clk);

        q0.push_back('{0, 'h1C});
        send_frame(0, 8, 'h1C, 1, 0, 1, -1, 0);
        drain(0);

        q0.push_back('{1, 'h1C});
        send_frame(0, 8, 'h1C, 1, 1, 1, -1, 0);
        drain(0);

        q0.push_back('{2, 'h1C});
        send_frame(0, 8, 'hF0, 1, 0, 0, -1, 0);
        drain(0);

        send_bit(0, 1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("busy_midframe0", int'(busy0), 1);
        q0.push_back('{3, 'h1C});
        repeat (5100) @(negedge clk);
        chk("busy_after_timeout0", int'(busy0), 0);
        drain(0);
        q0.push_back('{0, 'hE0});
        send_frame(0, 8, 'hE0, 1, 0, 1, -1, 0);
        drain(0);

        q0.push_back('{0, 'h5A});
        send_frame(0, 8, 'h5A, 1, 0, 1, 0, 3);
        drain(0);

        // The long glitch duplicates d0: word becomes 0xB4 with d7 taken as parity -> parity error.
        q0.push_back('{1, 'h5A});
        send_frame(0, 8, 'h5A, 1, 0, 1, 0, 4);
        drain(0);

        q1.push_back('{0, 'h55});
        send_frame(1, 7, 'h55, 0, 0, 1, -1, 0);
        drain(1);

        send_bit(1, 1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1, (i % 2 == 1), 0);
        rst1_n = 1'b0;
        ps2d[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_dout1", int'(dout1), 0);
        chk("midrst_busy1", int'(busy1), 0);
        chk("midrst_flags1", int'({valid1, ep1, ef1, et1}), 0);
        rst1_n = 1'b1;
        repeat (20) @(negedge clk);
        q1.push_back('{0, 'h2A});
        send_frame(1, 7, 'h2A, 0, 0, 1, -1, 0);
        drain(1);

        chk("final_dout0", int'(dout0), 'h5A);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
